// File: rtl/wb_mem_bist_pkg.sv
// Shared state encoding and test-pattern helper for the Wishbone memory BIST.
package wb_mem_bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int PAT_MAX_W = 64;

  // Word n of a test carries seed XOR n; callers truncate to their bus width.
  function automatic logic [PAT_MAX_W-1:0] pattern(input logic [PAT_MAX_W-1:0] seed,
                                                   input logic [PAT_MAX_W-1:0] n);
    return seed ^ n;
  endfunction

endpackage

// File: rtl/wb_mem_bist_wd.sv
// Ack watchdog: counts strobed cycles without ack, flags expiry on the TIMEOUT-th one.
module wb_mem_bist_wd #(
  parameter int TIMEOUT = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic stb,
  input  logic ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = '0;
    if (stb && !ack) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign expired = stb && !ack && (cnt_q == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_mem_bist.sv
// Wishbone BIST master: writes seed^n over a word range, reads it back and compares.
// Optional ack watchdog is enabled by defining WB_MEM_BIST_TIMEOUT_EN.
module wb_mem_bist
  import wb_mem_bist_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int CNT_WIDTH    = 16,
  parameter int TIMEOUT      = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDR_WIDTH-1:0]   base_addr,
  input  logic [CNT_WIDTH-1:0]    word_count,
  input  logic [DATA_WIDTH-1:0]   seed,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic                    timeout,
  output logic [ADDR_WIDTH-1:0]   fail_addr,
  output logic [DATA_WIDTH-1:0]   fail_data,
  output logic [ADDR_WIDTH-1:0]   adr_o,
  input  logic [DATA_WIDTH-1:0]   dat_i,
  output logic [DATA_WIDTH-1:0]   dat_o,
  output logic                    we_o,
  output logic [SELECT_WIDTH-1:0] sel_o,
  output logic                    stb_o,
  input  logic                    ack_i,
  output logic                    cyc_o
);

  state_t                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    n_q, n_d;
  logic                    busy_q, busy_d, done_q, done_d, pass_q, pass_d, timeout_q, timeout_d;
  logic [ADDR_WIDTH-1:0]   fail_addr_q, fail_addr_d, adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   fail_data_q, fail_data_d, dat_q, dat_d;
  logic                    we_q, we_d, stb_q, stb_d;
  logic [ADDR_WIDTH-1:0]   base_q, base_d;
  logic [CNT_WIDTH-1:0]    cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   seed_q, seed_d;

  logic [ADDR_WIDTH-1:0]   word_adr;
  logic [DATA_WIDTH-1:0]   word_pat;
  logic                    last_word;
  logic                    wd_expired;

  // Address arithmetic is modulo 2^ADDR_WIDTH, so ranges near the top wrap to zero.
  assign word_adr  = base_q + ADDR_WIDTH'(n_q) * ADDR_WIDTH'(SELECT_WIDTH);
  assign word_pat  = DATA_WIDTH'(pattern(PAT_MAX_W'(seed_q), PAT_MAX_W'(n_q)));
  assign last_word = (n_q == cnt_q - 1'b1);

`ifdef WB_MEM_BIST_TIMEOUT_EN
  wb_mem_bist_wd #(
    .TIMEOUT (TIMEOUT)
  ) u_wd (
    .clk     (clk),
    .rst     (rst),
    .stb     (stb_q),
    .ack     (ack_i),
    .expired (wd_expired)
  );
`else
  localparam int unused_timeout = TIMEOUT;
  assign wd_expired = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    n_d         = n_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pass_d      = pass_q;
    timeout_d   = timeout_q;
    fail_addr_d = fail_addr_q;
    fail_data_d = fail_data_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    we_d        = we_q;
    stb_d       = stb_q;
    base_d      = base_q;
    cnt_d       = cnt_q;
    seed_d      = seed_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          base_d      = base_addr;
          cnt_d       = word_count;
          seed_d      = seed;
          n_d         = '0;
          busy_d      = 1'b1;
          timeout_d   = 1'b0;
          fail_addr_d = '0;
          fail_data_d = '0;
          pass_d      = (word_count == '0);
          state_d     = (word_count == '0) ? DONE : WRITE;
        end
      end
      WRITE, READ: begin
        if (!stb_q) begin
          // Strobe is low here for at least one cycle after every ack.
          stb_d = 1'b1;
          we_d  = (state_q == WRITE);
          adr_d = word_adr;
          dat_d = word_pat;
        end else if (ack_i) begin
          stb_d = 1'b0;
          n_d   = n_q + 1'b1;
          if (state_q == READ && dat_i != word_pat) begin
            fail_addr_d = adr_q;
            fail_data_d = dat_i;
            pass_d      = 1'b0;
            state_d     = DONE;
          end else if (last_word) begin
            n_d = '0;
            if (state_q == WRITE) begin
              state_d = READ;
            end else begin
              pass_d  = 1'b1;
              state_d = DONE;
            end
          end
        end else if (wd_expired) begin
          stb_d       = 1'b0;
          timeout_d   = 1'b1;
          pass_d      = 1'b0;
          fail_addr_d = adr_q;
          fail_data_d = '0;
          state_d     = DONE;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      n_q         <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      timeout_q   <= 1'b0;
      fail_addr_q <= '0;
      fail_data_q <= '0;
      adr_q       <= '0;
      dat_q       <= '0;
      we_q        <= 1'b0;
      stb_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      n_q         <= n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pass_q      <= pass_d;
      timeout_q   <= timeout_d;
      fail_addr_q <= fail_addr_d;
      fail_data_q <= fail_data_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      we_q        <= we_d;
      stb_q       <= stb_d;
    end
  end

  // Test parameters are only meaningful while busy, so they carry no reset.
  always_ff @(posedge clk) begin
    base_q <= base_d;
    cnt_q  <= cnt_d;
    seed_q <= seed_d;
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign timeout   = timeout_q;
  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
  assign adr_o     = adr_q;
  assign dat_o     = dat_q;
  assign we_o      = we_q;
  assign stb_o     = stb_q;
  assign sel_o     = {SELECT_WIDTH{stb_q}};
  assign cyc_o     = busy_q;

endmodule

// File: doc/wb_mem_bist.md
# wb_mem_bist

Wishbone master that runs a built-in self test on a word-addressed Wishbone memory slave, such as the single-port Wishbone RAM. It sits directly upstream of the RAM and drives its slave port. A test writes a seed-derived pattern over a programmed address range, reads the range back and compares each word. It reports pass/fail and the first failing address and data.

## Interface
- DATA_WIDTH, 32, data bus width in bits (8, 16, 32, 64)
- ADDR_WIDTH, 32, byte address width
- SELECT_WIDTH, DATA_WIDTH/8, byte-select width
- CNT_WIDTH, 16, width of the word-count input
- TIMEOUT, 1024, cycles without ack before abort (used only with timeout enabled)

Ports:
- clk  in  1  system clock
- rst  in  1  reset; one clock; reset is asynchronous and active-high
- start  in  1  single-cycle pulse that begins a test; sampled only in IDLE
- base_addr  in  ADDR_WIDTH  byte address of word 0; must be aligned to SELECT_WIDTH
- word_count  in  CNT_WIDTH  number of words to test
- seed  in  DATA_WIDTH  pattern seed
- busy  out  1  test in progress
- done  out  1  one-cycle pulse at end of test
- pass  out  1  result of the last test; held until the next start
- timeout  out  1  last test aborted on timeout
- fail_addr  out  ADDR_WIDTH  byte address of the first mismatch
- fail_data  out  DATA_WIDTH  data read at the first mismatch
- adr_o  out  ADDR_WIDTH  Wishbone address
- dat_i  in  DATA_WIDTH  Wishbone read data
- dat_o  out  DATA_WIDTH  Wishbone write data
- we_o  out  1  Wishbone write enable
- sel_o  out  SELECT_WIDTH  byte select; always all ones while stb_o is high
- stb_o  out  1  Wishbone strobe
- ack_i  in  1  Wishbone acknowledge
- cyc_o  out  1  Wishbone cycle; equal to busy

## Operation
- States: IDLE, WRITE, READ, DONE.
- Pattern: pattern(n) = seed XOR n, with n zero-extended to DATA_WIDTH. Address of word n = base_addr + n*SELECT_WIDTH, computed modulo 2^ADDR_WIDTH so the address wraps.
- IDLE, start=1, word_count=0: go to DONE with pass=1; no bus traffic.
- IDLE, start=1, word_count>0: latch base_addr, word_count and seed; clear pass, timeout, fail_addr and fail_data; set n=0; enter WRITE.
- WRITE: issue a write of pattern(n) to the address of word n. On ack, increment n. After the last word, set n=0 and enter READ.
- READ: issue a read of word n. On ack, compare dat_i with pattern(n) over all bits.
  - On mismatch: capture fail_addr and fail_data, set pass=0, enter DONE.
  - After the last word matches: set pass=1, enter DONE.
- DONE: drive done=1 for one cycle, then return to IDLE.
- start is ignored while busy=1.
- Reset mid-test drops the bus at once (stb_o=0, cyc_o=0) and returns to IDLE. The partially written memory is left as is.

## Timing
- Reset values: all outputs 0, and the FSM is in IDLE.
- All outputs are registered.
- Access sequence:
  - stb_o rises on the clock edge after the decision to access.
  - stb_o is held with adr_o, dat_o and we_o stable until ack_i is sampled high.
  - stb_o falls on that same edge and stays low for at least one cycle before the next access.
- Against a slave with one-cycle ack latency, each access takes 3 cycles. Total test length is 6*word_count + 2 cycles from start to done, ±1 cycle.
- ack_i while stb_o=0 is ignored.
- busy rises on the edge after start and falls on the edge where done rises.
- fail_addr, fail_data, pass and timeout are stable whenever done=1 and hold until the next accepted start.

## Configuration
- WB_MEM_BIST_TIMEOUT_EN defined:
  - A watchdog counts cycles with stb_o=1 and ack_i=0, and clears on every ack.
  - On reaching TIMEOUT the block drops stb_o, sets timeout=1 and pass=0, sets fail_addr to the current address and fail_data to 0, then enters DONE.
- Not defined: no watchdog; the timeout output is tied to 0 and the block waits indefinitely for ack.

## Structure
- Shared package wb_mem_bist_pkg:
  - FSM state encoding localparams (IDLE=0, WRITE=1, READ=2, DONE=3).
  - Pattern function taking seed and n.
- One sub-module, wb_mem_bist_wd: the watchdog counter, instantiated only under WB_MEM_BIST_TIMEOUT_EN.

## Test plan
- Good RAM, base_addr=0x100, word_count=4, seed=0xA5A5A5A5 -> writes 0xA5A5A5A5, 0xA5A5A5A4, 0xA5A5A5A7, 0xA5A5A5A6 to 0x100, 0x104, 0x108, 0x10C; the readback matches; done with pass=1.
- RAM model with bit 3 of the word at 0x108 stuck at 0, seed=0xFFFFFFFF, word_count=4 -> pass=0, fail_addr=0x108, fail_data=0xFFFFFFF5; done after the third read, with no fourth read.
- word_count=0 -> no stb_o; done two cycles after start; pass=1.
- Assert rst during the READ of word 2 -> stb_o, cyc_o and busy go to 0 immediately; a new start runs a complete test.
- With WB_MEM_BIST_TIMEOUT_EN and TIMEOUT=16, slave never acks -> stb_o drops after 16 cycles; timeout=1, pass=0, fail_addr=base_addr.
- A second start pulse while busy, and base_addr=0xFFFFFFF8 with word_count=4 -> the second start is ignored; the addresses wrap as 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4; pass=1.
